// File: rtl/fmab_seq_pkg.sv
// Shared constants and types for the fmab job sequencer.
package fmab_seq_pkg;

  // Integer commands understood by the fmab lane.
  localparam int CMD_MAC = 0;
  localparam int CMD_CLR = 1;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fmab_seq_fifo.sv
// Operand beat FIFO: DEPTH x W synchronous FIFO with the head word visible.
// Pushes while full and pops while empty are ignored. There is no bypass.
module fmab_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fmab_seq.sv
// Job sequencer feeding one fmab quad bf16-pair MAC lane.
// Buffers operand beats, issues a job of len beats (first beat clears the
// accumulators), waits out the fmab pipeline and hands off acc/exp results.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; in_valid/in_x..in_w must stay stable until accepted, and
// res_valid/res_acc/res_exp are held stable until res_ready is seen.
// Optional build macro FMAB_SEQ_STALL_CNT_EN adds the stall_cnt output.
module fmab_seq
  import fmab_seq_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [31:0]      in_z,
  input  logic [31:0]      in_w,
  output logic             req,
  output logic [31:0]      req_command,
  output logic [31:0]      x,
  output logic [31:0]      y,
  output logic [31:0]      z,
  output logic [31:0]      w,
  input  logic [31:0]      acc0,
  input  logic [31:0]      acc1,
  input  logic [31:0]      acc2,
  input  logic [31:0]      acc3,
  input  logic [9:0]       exp0,
  input  logic [9:0]       exp1,
  input  logic [9:0]       exp2,
  input  logic [9:0]       exp3,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [127:0]     res_acc,
  output logic [39:0]      res_exp,
  output state_t           dbg_state
`ifdef FMAB_SEQ_STALL_CNT_EN
  , output logic [15:0]    stall_cnt
`endif
);

  localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] rem;
  logic             first;
  logic [DW-1:0]    dcnt;
  logic             full;
  logic             empty;
  logic [127:0]     head;
  logic             accept;
  logic             issue;
  logic             last_issue;
  logic             capture;

  assign accept     = (state == ST_IDLE) && start && (len != '0);
  assign issue      = (state == ST_RUN) && !empty;
  assign last_issue = issue && (rem == LEN_W'(1));
  assign capture    = (state == ST_DRAIN) && (dcnt == '0);
  assign busy       = (state != ST_IDLE);
  assign in_ready   = !full;
  assign dbg_state  = state;

  fmab_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (128)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (issue),
    .din   ({in_x, in_y, in_z, in_w}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept)     state_next = ST_RUN;
      ST_RUN:   if (last_issue) state_next = ST_DRAIN;
      ST_DRAIN: if (capture)    state_next = ST_DONE;
      ST_DONE:  if (res_ready)  state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // Job bookkeeping: remaining beats, clear-tag flag and pipeline drain count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem   <= '0;
      first <= 1'b0;
      dcnt  <= '0;
    end else begin
      if (accept) begin
        rem   <= len;
        first <= 1'b1;
      end else if (issue) begin
        rem   <= rem - LEN_W'(1);
        first <= 1'b0;
      end
      if (last_issue)                            dcnt <= DW'(PIPE_LAT);
      else if (state == ST_DRAIN && dcnt != '0)  dcnt <= dcnt - DW'(1);
    end
  end

  // Issue port: req/command are one-cycle strobes, operands hold between issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req         <= 1'b0;
      req_command <= 32'(CMD_MAC);
      x           <= '0;
      y           <= '0;
      z           <= '0;
      w           <= '0;
    end else begin
      req         <= issue;
      req_command <= (issue && first) ? 32'(CMD_CLR) : 32'(CMD_MAC);
      if (issue) {x, y, z, w} <= head;
    end
  end

  // Result snapshot and hand-off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_acc   <= '0;
      res_exp   <= '0;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_acc   <= {acc0, acc1, acc2, acc3};
        res_exp   <= {exp0, exp1, exp2, exp3};
      end else if (state == ST_DONE && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef FMAB_SEQ_STALL_CNT_EN
  // Saturating count of RUN cycles spent waiting on an empty FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                              stall_cnt <= '0;
    else if (accept)                                         stall_cnt <= '0;
    else if (state == ST_RUN && empty && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fmab_seq.sv
// Self-checking bench for fmab_seq: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
module tb_fmab_seq;
  import fmab_seq_pkg::*;

  localparam int DEPTH    = 4;
  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 3;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x, in_y, in_z, in_w;
  logic             req;
  logic [31:0]      req_command;
  logic [31:0]      x, y, z, w;
  logic [31:0]      acc0, acc1, acc2, acc3;
  logic [9:0]       exp0, exp1, exp2, exp3;
  logic             res_valid;
  logic             res_ready;
  logic [127:0]     res_acc;
  logic [39:0]      res_exp;
  state_t           dbg_state;
`ifdef FMAB_SEQ_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  fmab_seq #(
    .DEPTH    (DEPTH),
    .LEN_W    (LEN_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .len         (len),
    .busy        (busy),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_z        (in_z),
    .in_w        (in_w),
    .req         (req),
    .req_command (req_command),
    .x           (x),
    .y           (y),
    .z           (z),
    .w           (w),
    .acc0        (acc0),
    .acc1        (acc1),
    .acc2        (acc2),
    .acc3        (acc3),
    .exp0        (exp0),
    .exp1        (exp1),
    .exp2        (exp2),
    .exp3        (exp3),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_acc     (res_acc),
    .res_exp     (res_exp),
    .dbg_state   (dbg_state)
`ifdef FMAB_SEQ_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- reference model / scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] exp_q[$];     // beats expected to be issued, in order
  int           m_phase;
  int           m_rem;
  bit           m_first;
  int           cyc;          // index of the next rising edge
  int           m_res_at;     // edge at which the result is snapshotted
  bit           e_req;
  logic [31:0]  e_cmd;
  logic [127:0] e_ops;
  bit           e_rv;
  logic [127:0] e_acc;
  logic [39:0]  e_exp;
  int           m_stall;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_phase = P_IDLE;
    m_rem   = 0;
    m_first = 0;
    e_req   = 0;
    e_cmd   = CMD_MAC;
    e_ops   = '0;
    e_rv    = 0;
    e_acc   = '0;
    e_exp   = '0;
    m_stall = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit rdy;
    bit issue;
    int old;
    rdy   = exp_q.size() < DEPTH;
    issue = (m_phase == P_RUN) && (exp_q.size() > 0);
    old   = m_phase;
    if (old == P_RUN && exp_q.size() == 0 && m_stall < 65535) m_stall++;
    e_req = issue;
    e_cmd = (issue && m_first) ? CMD_CLR : CMD_MAC;
    if (issue) begin
      e_ops   = exp_q.pop_front();
      m_first = 0;
      m_rem--;
      if (m_rem == 0) begin
        m_phase  = P_DRAIN;
        m_res_at = cyc + PIPE_LAT + 1;
      end
    end
    case (old)
      P_IDLE: if (start && len != 0) begin
        m_phase = P_RUN;
        m_rem   = len;
        m_first = 1;
        m_stall = 0;
      end
      P_DRAIN: if (cyc == m_res_at) begin
        m_phase = P_DONE;
        e_rv    = 1;
        e_acc   = {acc0, acc1, acc2, acc3};
        e_exp   = {exp0, exp1, exp2, exp3};
      end
      P_DONE: if (res_ready) begin
        m_phase = P_IDLE;
        e_rv    = 0;
      end
      default: ;
    endcase
    if (in_valid && rdy) exp_q.push_back({in_x, in_y, in_z, in_w});
    cyc++;
  endtask

  task automatic check_all();
    chk("req", req, e_req);
    chk("req_command", req_command, e_cmd);
    chk("xyzw", {x, y, z, w}, e_ops);
    chk("res_valid", res_valid, e_rv);
    chk("res_acc", res_acc, e_acc);
    chk("res_exp", res_exp, e_exp);
    chk("busy", busy, m_phase != P_IDLE);
    chk("in_ready", in_ready, exp_q.size() < DEPTH);
`ifdef FMAB_SEQ_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input bit st, input int ln, input bit rr);
    in_valid  = v;
    start     = st;
    len       = LEN_W'(ln);
    res_ready = rr;
    in_x = $urandom; in_y = $urandom; in_z = $urandom; in_w = $urandom;
    acc0 = $urandom; acc1 = $urandom; acc2 = $urandom; acc3 = $urandom;
    exp0 = 10'($urandom); exp1 = 10'($urandom);
    exp2 = 10'($urandom); exp3 = 10'($urandom);
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_to_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (m_phase == P_IDLE) break;
      step(0, 0, 0, 1);
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int           last_req;
    int           rv_at;
    int           nreq;
    int           sent;
    logic [127:0] held_acc;
    logic [39:0]  held_exp;

    rst_n = 1'b0;
    in_valid = 0; start = 0; len = '0; res_ready = 0;
    in_x = '0; in_y = '0; in_z = '0; in_w = '0;
    acc0 = '0; acc1 = '0; acc2 = '0; acc3 = '0;
    exp0 = '0; exp1 = '0; exp2 = '0; exp3 = '0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Prefill three beats in IDLE, then a len=3 job.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 1, 3, 0);
    last_req = -1; rv_at = -1; nreq = 0;
    for (int i = 0; i < 20 && rv_at < 0; i++) begin
      step(0, 0, 0, 0);
      if (req) begin last_req = i; nreq++; end
      if (res_valid) rv_at = i;
    end
    chk("len3_req_count", nreq, 3);
    chk("len3_res_latency", rv_at - last_req, PIPE_LAT + 1);

    // Result held while res_ready is low; a start during DONE is ignored.
    held_acc = res_acc;
    held_exp = res_exp;
    for (int i = 0; i < 5; i++) step(0, (i == 2), 2, 0);
    chk("hold_valid", res_valid, 1'b1);
    chk("hold_acc", res_acc, held_acc);
    chk("hold_exp", res_exp, held_exp);
    step(0, 0, 0, 1);
    chk("busy_drop", busy, 1'b0);

    // len=4 with beats arriving every other cycle.
    step(0, 1, 4, 1);
    sent = 0; nreq = 0;
    for (int i = 0; i < 30; i++) begin
      step((i % 2 == 0) && sent < 4, 0, 0, 1);
      if ((i % 2 == 0) && sent < 4) sent++;
      if (req) nreq++;
    end
    chk("len4_req_count", nreq, 4);
    run_to_idle(20);

    // Fill the FIFO with no job, then run a job while pushing at full.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("full_in_ready", in_ready, 1'b0);
    step(1, 0, 0, 0);
    step(1, 1, 6, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    run_to_idle(20);
    // Drain any leftover beats with a job sized to the model's backlog.
    if (exp_q.size() > 0) begin
      step(0, 1, exp_q.size(), 1);
      run_to_idle(30);
    end

    // len=0 is ignored; len=1 issues a single clear command.
    step(0, 1, 0, 1);
    chk("len0_busy", busy, 1'b0);
    step(0, 0, 0, 1);
    chk("len0_no_req", req, 1'b0);
    step(1, 1, 1, 1);
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1);
      if (req) begin
        nreq++;
        chk("len1_cmd", req_command, CMD_CLR);
      end
    end
    chk("len1_req_count", nreq, 1);
    run_to_idle(10);

    // Reset asserted mid-job after two of five issues.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 1, 5, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0);
    step(0, 1, 2, 1);
    run_to_idle(20);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 6), $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
